// File: rtl/reg_bus_arb_if.sv
// reg_bus_arb_if -- bundle of two requester ports and one shared downstream
// register bus.
//
// Handshake: a requester raises sN_rd or sN_wr (with sN_addr/sN_writedata)
// and holds all of them unchanged until it sees the one-cycle sN_ready pulse;
// sN_readdata is valid in that same cycle. Downstream, m_rd/m_wr and the
// address/data stay constant until the cycle where m_ready is high; m_readdata
// is taken in that cycle. There is no back-pressure beyond these two levels.
//
// Modports:
//   slave  -- arbiter side (takes requests, drives the downstream bus)
//   master -- environment side (requesters plus downstream target)
//
// Parameter: AW -- register address width.

interface reg_bus_arb_if #(
  parameter int AW = 14
);
  logic [AW-1:0] s0_addr;
  logic          s0_rd;
  logic          s0_wr;
  logic [31:0]   s0_writedata;
  logic          s0_ready;
  logic [31:0]   s0_readdata;

  logic [AW-1:0] s1_addr;
  logic          s1_rd;
  logic          s1_wr;
  logic [31:0]   s1_writedata;
  logic          s1_ready;
  logic [31:0]   s1_readdata;

  logic [AW-1:0] m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [31:0]   m_writedata;
  logic          m_ready;
  logic [31:0]   m_readdata;

  modport slave (
    input  s0_addr, s0_rd, s0_wr, s0_writedata,
    output s0_ready, s0_readdata,
    input  s1_addr, s1_rd, s1_wr, s1_writedata,
    output s1_ready, s1_readdata,
    output m_addr, m_rd, m_wr, m_writedata,
    input  m_ready, m_readdata
  );

  modport master (
    output s0_addr, s0_rd, s0_wr, s0_writedata,
    input  s0_ready, s0_readdata,
    output s1_addr, s1_rd, s1_wr, s1_writedata,
    input  s1_ready, s1_readdata,
    input  m_addr, m_rd, m_wr, m_writedata,
    output m_ready, m_readdata
  );
endinterface

// File: rtl/reg_bus_arb.sv
// reg_bus_arb -- round-robin arbiter giving two register-bus requesters
// access to one shared downstream register bus.
//
// Ports:
//   clk, rst_n  -- single rising-edge clock, asynchronous active-low reset
//   bus         -- reg_bus_arb_if.slave: requester ports s0/s1, downstream m_*
//   grant       -- one-hot owner of the downstream bus, 0 when idle
//   timeout_err -- sticky watchdog flag (always 0 without the watchdog)
//   dbg_state   -- current FSM state (0 IDLE, 1 BUSY, 2 RELEASE)
//
// Parameters: AW (address width), TIMEOUT (1..255 downstream wait cycles).
// Optional feature: define REG_BUS_ARB_TIMEOUT_EN to enable the watchdog that
// completes a stalled transaction after TIMEOUT cycles without m_ready.

module reg_bus_arb #(
  parameter int AW      = 14,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_bus_arb_if.slave bus,
  output logic [1:0]   grant,
  output logic         timeout_err,
  output logic [1:0]   dbg_state
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("reg_bus_arb: TIMEOUT must lie in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;     // 0 = port 0, 1 = port 1
  logic          ptr_q, ptr_d;         // round-robin preference
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic          m_rd_q, m_rd_d;
  logic          m_wr_q, m_wr_d;
  logic          s0_ready_q, s0_ready_d;
  logic          s1_ready_q, s1_ready_d;
  logic [31:0]   s0_rdata_q, s0_rdata_d;
  logic [31:0]   s1_rdata_q, s1_rdata_d;
  logic [1:0]    grant_q, grant_d;

  logic          req0, req1, win, complete, timed_out;
  logic [31:0]   cap_data;

`ifdef REG_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_rd_d     = m_rd_q;
    m_wr_d     = m_wr_q;
    s0_ready_d = 1'b0;
    s1_ready_d = 1'b0;
    s0_rdata_d = s0_rdata_q;
    s1_rdata_d = s1_rdata_q;
    grant_d    = grant_q;
    req0       = bus.s0_rd | bus.s0_wr;
    req1       = bus.s1_rd | bus.s1_wr;
    // Port 1 wins when it is the only requester, or both request and the
    // pointer favours it.
    win        = req1 & (~req0 | ptr_q);
    complete   = 1'b0;
    timed_out  = 1'b0;
    cap_data   = bus.m_readdata;
`ifdef REG_BUS_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d   = win;
          m_addr_d  = win ? bus.s1_addr : bus.s0_addr;
          m_wdata_d = win ? bus.s1_writedata : bus.s0_writedata;
          // A simultaneous rd+wr is treated as a write.
          m_wr_d    = win ? bus.s1_wr : bus.s0_wr;
          m_rd_d    = win ? (bus.s1_rd & ~bus.s1_wr) : (bus.s0_rd & ~bus.s0_wr);
          grant_d   = win ? 2'b10 : 2'b01;
          state_d   = BUSY;
`ifdef REG_BUS_ARB_TIMEOUT_EN
          to_cnt_d  = 8'd0;
`endif
        end
      end

      BUSY: begin
        complete = bus.m_ready;
`ifdef REG_BUS_ARB_TIMEOUT_EN
        if (!bus.m_ready) begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_d == TO_LIMIT) begin
            complete  = 1'b1;
            timed_out = 1'b1;
          end
        end
`endif
        if (complete) begin
          state_d  = RELEASE;
          m_rd_d   = 1'b0;
          m_wr_d   = 1'b0;
          ptr_d    = ~owner_q;
          cap_data = timed_out ? 32'hDEADBEEF : bus.m_readdata;
          if (owner_q) begin
            s1_ready_d = 1'b1;
            if (m_rd_q) s1_rdata_d = cap_data;
          end else begin
            s0_ready_d = 1'b1;
            if (m_rd_q) s0_rdata_d = cap_data;
          end
`ifdef REG_BUS_ARB_TIMEOUT_EN
          if (timed_out) timeout_err_d = 1'b1;
`endif
        end
      end

      RELEASE: begin
        // Requests seen here are deliberately not evaluated; the owner is
        // still dropping its request in response to sN_ready.
        grant_d = 2'b00;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      ptr_q         <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_rd_q        <= 1'b0;
      m_wr_q        <= 1'b0;
      s0_ready_q    <= 1'b0;
      s1_ready_q    <= 1'b0;
      s0_rdata_q    <= '0;
      s1_rdata_q    <= '0;
      grant_q       <= 2'b00;
`ifdef REG_BUS_ARB_TIMEOUT_EN
      to_cnt_q      <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_rd_q        <= m_rd_d;
      m_wr_q        <= m_wr_d;
      s0_ready_q    <= s0_ready_d;
      s1_ready_q    <= s1_ready_d;
      s0_rdata_q    <= s0_rdata_d;
      s1_rdata_q    <= s1_rdata_d;
      grant_q       <= grant_d;
`ifdef REG_BUS_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.m_addr      = m_addr_q;
  assign bus.m_writedata = m_wdata_q;
  assign bus.m_rd        = m_rd_q;
  assign bus.m_wr        = m_wr_q;
  assign bus.s0_ready    = s0_ready_q;
  assign bus.s1_ready    = s1_ready_q;
  assign bus.s0_readdata = s0_rdata_q;
  assign bus.s1_readdata = s1_rdata_q;
  assign grant           = grant_q;
  assign dbg_state       = state_q;
`ifdef REG_BUS_ARB_TIMEOUT_EN
  assign timeout_err     = timeout_err_q;
`else
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: doc/reg_bus_arb.md
REG_BUS_ARB -- requirements
Module: reg_bus_arb

Interface
REQ-001 SHALL have parameter AW, default 14, register address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max downstream wait cycles (8-bit counter).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports sN_addr  in  AW  requester N (N=0,1) register address.
REQ-006 SHALL have ports sN_rd / sN_wr  in  1  requester N read/write request level, held until sN_ready.
REQ-007 SHALL have ports sN_writedata  in  32  requester N write data.
REQ-008 SHALL have ports sN_ready  out  1  one-cycle completion pulse to requester N.
REQ-009 SHALL have ports sN_readdata  out  32  requester N read data, valid with sN_ready.
REQ-010 SHALL have ports m_addr out AW, m_rd out 1, m_wr out 1, m_writedata out 32 -- shared downstream register bus.
REQ-011 SHALL have ports m_ready in 1, m_readdata in 32 -- downstream completion and read data.
REQ-012 SHALL have port grant  out  2  one-hot current owner, 0 when idle.
REQ-013 SHALL have port timeout_err  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, BUSY, RELEASE.
REQ-015 IDLE: if sN_rd|sN_wr for any N, SHALL pick winner, latch its addr/writedata/op, assert grant, enter BUSY next cycle with m_rd or m_wr registered high.
REQ-016 Arbitration SHALL be round-robin: pointer starts at port 0; after each completion it moves to the other port; with both requesting, pointer port wins; with one requesting, it wins regardless of pointer.
REQ-017 If a requester asserts rd and wr together, wr SHALL take precedence; rd ignored for that transaction.
REQ-018 BUSY: m_addr, m_writedata, m_rd/m_wr SHALL stay stable until m_ready sampled high.
REQ-019 On m_ready=1 in BUSY, next cycle: m_rd/m_wr=0, sN_ready=1 for owner only (one cycle), sN_readdata=m_readdata captured (read) or unchanged (write), state RELEASE.
REQ-020 RELEASE SHALL last exactly one cycle, grant cleared at its end, then IDLE; requests sampled during RELEASE SHALL be ignored.
REQ-021 Minimum request-to-m_rd/m_wr latency SHALL be 1 cycle; m_ready-to-sN_ready latency 1 cycle; back-to-back transaction spacing minimum 3 cycles.
REQ-022 Non-owner sN_ready SHALL stay 0; non-owner sN_readdata SHALL hold its last value.
REQ-023 m_ready outside BUSY SHALL be ignored.

Reset
REQ-024 On rst_n=0 (any time, mid-transaction included) SHALL immediately force: state IDLE, m_rd=m_wr=0, m_addr=0, m_writedata=0, sN_ready=0, sN_readdata=0, grant=0, pointer=port 0, timeout counter=0, timeout_err=0.
REQ-025 An interrupted transaction SHALL NOT be completed or replayed after reset release.

Configuration
REQ-026 Macro REG_BUS_ARB_TIMEOUT_EN SHALL enable the timeout watchdog.
REQ-027 With macro: counter clears on BUSY entry, increments each BUSY cycle with m_ready=0; on reaching TIMEOUT, transaction SHALL complete as REQ-019 with sN_readdata=32'hDEADBEEF (reads only) and timeout_err set, sticky until reset.
REQ-028 Without macro: no counter; BUSY waits indefinitely for m_ready; timeout_err tied 0.

Verification
REQ-029 s0_wr, addr 0x0010, data 0x12345678; m_ready after 4 cycles -> m_wr high 5 cycles with stable addr/data, s0_ready single pulse, grant 01 then 00.
REQ-030 s1_rd addr 0x0020; m_readdata 0xCAFEF00D with m_ready -> s1_readdata=0xCAFEF00D with s1_ready pulse, s0_ready stays 0.
REQ-031 s0 and s1 request same cycle repeatedly, 4 transactions -> grant order 01,10,01,10.
REQ-032 rst_n pulsed low while BUSY -> all outputs zero same cycle, no sN_ready after release, next request granted to port 0.
REQ-033 With REG_BUS_ARB_TIMEOUT_EN, TIMEOUT=8, s0_rd, m_ready never asserted -> s0_ready after 8 BUSY cycles, s0_readdata=0xDEADBEEF, timeout_err=1 and held.
